// File: rtl/prog_loader.sv
// Instruction-memory loader: takes a framed byte stream (count, LE words, XOR checksum),
// writes words from address 0 and holds the core in reset until the load checks out.
module prog_loader #(
    parameter int ADDR_W    = 10,
    parameter int MAX_WORDS = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic              reload,
    output logic              ins_write_en,
    output logic [ADDR_W-1:0] ins_write_addr,
    output logic [31:0]       ins_write_data,
    output logic              cpu_reset,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-2:0] words_loaded
);

    localparam int WL_W = ADDR_W - 1;

    typedef enum logic [2:0] {HDR0, HDR1, DATA, WRITE, CHK, DONE, ERR} state_t;

    state_t            state_q, state_d;
    logic [15:0]       count_q, count_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [31:0]       word_q, word_d;
    logic [7:0]        csum_q, csum_d;
    logic [WL_W-1:0]   word_idx_q, word_idx_d;
    logic [WL_W-1:0]   wl_q, wl_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]       wr_data_q, wr_data_d;
    logic              cpu_reset_q, cpu_reset_d;
    logic              done_q, done_d;
    logic              error_q, error_d;

    logic              accept;
    logic [15:0]       hdr_cnt;
    logic [15:0]       next_idx;

    // in_ready is gated by reset directly so it drops the moment reset asserts
    assign in_ready = reset && (state_q == HDR0 || state_q == HDR1 ||
                                state_q == DATA || state_q == CHK);
    assign accept   = in_valid && in_ready;
    assign hdr_cnt  = {in_data, count_q[7:0]};
    assign next_idx = 16'(word_idx_q) + 16'd1;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        byte_cnt_d  = byte_cnt_q;
        word_d      = word_q;
        csum_d      = csum_q;
        word_idx_d  = word_idx_q;
        wl_d        = wl_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        cpu_reset_d = cpu_reset_q;
        done_d      = done_q;
        error_d     = error_q;

        case (state_q)
            HDR0: begin
                if (accept) begin
                    count_d[7:0] = in_data;
                    state_d      = HDR1;
                end
            end
            HDR1: begin
                if (accept) begin
                    count_d[15:8] = in_data;
                    byte_cnt_d    = 2'd0;
                    if (hdr_cnt == 16'd0) begin
                        state_d = CHK;
                    end else if (hdr_cnt > 16'(MAX_WORDS)) begin
                        state_d = ERR;
                        error_d = 1'b1;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    // bytes shift in from the top, so the first byte ends up in [7:0]
                    word_d     = {in_data, word_q[31:8]};
                    csum_d     = csum_q ^ in_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d   = WRITE;
                        wr_en_d   = 1'b1;
                        wr_addr_d = {word_idx_q[ADDR_W-3:0], 2'b00};
                        wr_data_d = {in_data, word_q[31:8]};
                    end
                end
            end
            WRITE: begin
                word_idx_d = word_idx_q + 1'b1;
                wl_d       = wl_q + 1'b1;
                state_d    = (next_idx == count_q) ? CHK : DATA;
            end
            CHK: begin
                if (accept) begin
                    if (in_data == csum_q) begin
                        state_d     = DONE;
                        done_d      = 1'b1;
                        cpu_reset_d = 1'b0;
                    end else begin
                        state_d = ERR;
                        error_d = 1'b1;
                    end
                end
            end
            DONE, ERR: begin
                if (reload) begin
                    state_d     = HDR0;
                    cpu_reset_d = 1'b1;
                    done_d      = 1'b0;
                    error_d     = 1'b0;
                    wl_d        = '0;
                    word_idx_d  = '0;
                    csum_d      = 8'h00;
                    byte_cnt_d  = 2'd0;
                end
            end
            default: state_d = HDR0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= HDR0;
            count_q     <= 16'h0;
            byte_cnt_q  <= 2'd0;
            word_q      <= 32'h0;
            csum_q      <= 8'h00;
            word_idx_q  <= '0;
            wl_q        <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= 32'h0;
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            byte_cnt_q  <= byte_cnt_d;
            word_q      <= word_d;
            csum_q      <= csum_d;
            word_idx_q  <= word_idx_d;
            wl_q        <= wl_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            cpu_reset_q <= cpu_reset_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign ins_write_en   = wr_en_q;
    assign ins_write_addr = wr_addr_q;
    assign ins_write_data = wr_data_q;
    assign cpu_reset      = cpu_reset_q;
    assign done           = done_q;
    assign error          = error_q;
    assign words_loaded   = wl_q;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: a frame-level model queues expected writes,
// a negedge monitor pops and compares each strobe.
module tb_prog_loader;
    localparam int ADDR_W = 10;
    localparam int MAXW   = 256;

    typedef logic [7:0] bq_t[$];
    typedef struct { logic [ADDR_W-1:0] a; logic [31:0] d; } wr_t;

    logic              clk, reset, in_valid, in_ready, reload;
    logic [7:0]        in_data;
    logic              ins_write_en, cpu_reset, done, error;
    logic [ADDR_W-1:0] ins_write_addr;
    logic [31:0]       ins_write_data;
    logic [ADDR_W-2:0] words_loaded;

    int  n_cmp = 0;
    int  n_bad = 0;
    wr_t exp_q[$];
    wr_t e;
    logic prev_en = 1'b0;

    prog_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAXW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .reload(reload), .ins_write_en(ins_write_en),
        .ins_write_addr(ins_write_addr), .ins_write_data(ins_write_data),
        .cpu_reset(cpu_reset), .done(done), .error(error), .words_loaded(words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: every strobe must match the next expected write, one cycle wide.
    always @(negedge clk) begin
        if (ins_write_en) begin
            chk("strobe_width", {31'b0, prev_en}, 32'd0);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: addr %0h data %0h, none expected",
                         ins_write_addr, ins_write_data);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", 32'(ins_write_addr), 32'(e.a));
                chk("wr_data", ins_write_data, e.d);
            end
        end
        prev_en = ins_write_en;
    end

    // Frame-level reference: derive writes and outcome from the byte list.
    task automatic model(input bq_t fr, input int nsent,
                         output bit e_done, output bit e_err, output int e_wl);
        int n;
        logic [7:0] x;
        wr_t w;
        n = {fr[1], fr[0]};
        x = 8'h00;
        e_done = 1'b0; e_err = 1'b0; e_wl = 0;
        if (n > MAXW) begin
            e_err = (nsent >= 2);
            return;
        end
        for (int i = 0; i < n; i++) begin
            if (2 + 4*i + 4 <= nsent) begin
                w.a = ADDR_W'(i * 4);
                w.d = {fr[2+4*i+3], fr[2+4*i+2], fr[2+4*i+1], fr[2+4*i]};
                exp_q.push_back(w);
                e_wl++;
            end
        end
        for (int i = 0; i < 4*n; i++) x ^= fr[2+i];
        if (nsent == 4*n + 3) begin
            if (fr[4*n+2] == x) e_done = 1'b1;
            else e_err = 1'b1;
        end
    endtask

    // Called just after a negedge; returns just after the negedge following acceptance.
    task automatic send_byte(input logic [7:0] b, input bit rnd);
        bit acc;
        int tries;
        acc = 1'b0;
        tries = 0;
        if (rnd) begin
            repeat ($urandom_range(0, 3)) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                @(negedge clk);
            end
        end
        in_valid = 1'b1;
        in_data  = b;
        while (!acc) begin
            #1;
            acc = in_ready;
            @(posedge clk);
            @(negedge clk);
            tries++;
            if (!acc && tries > 40) begin
                n_cmp++;
                n_bad++;
                $display("FAIL accept_timeout: byte %0h never accepted, expected acceptance", b);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic run(input bq_t fr, input bit rnd, input int nsent, input string tag);
        bit ed, ee;
        int ew;
        model(fr, nsent, ed, ee, ew);
        for (int i = 0; i < nsent; i++) send_byte(fr[i], rnd);
        if (nsent == fr.size()) begin
            #1;
            chk({tag, ".done"},      {31'b0, done},      {31'b0, ed});
            chk({tag, ".error"},     {31'b0, error},     {31'b0, ee});
            chk({tag, ".cpu_reset"}, {31'b0, cpu_reset}, {31'b0, !ed});
            chk({tag, ".words"},     32'(words_loaded),  32'(ew));
            chk({tag, ".in_ready"},  {31'b0, in_ready},  32'd0);
            chk({tag, ".pending"},   32'(exp_q.size()),  32'd0);
        end
    endtask

    task automatic do_reload();
        reload = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reload = 1'b0;
        #1;
        chk("reload.done",      {31'b0, done},      32'd0);
        chk("reload.error",     {31'b0, error},     32'd0);
        chk("reload.cpu_reset", {31'b0, cpu_reset}, 32'd1);
        chk("reload.words",     32'(words_loaded),  32'd0);
        chk("reload.in_ready",  {31'b0, in_ready},  32'd1);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, ".in_ready"},  {31'b0, in_ready},     32'd0);
        chk({tag, ".wr_en"},     {31'b0, ins_write_en}, 32'd0);
        chk({tag, ".wr_addr"},   32'(ins_write_addr),   32'd0);
        chk({tag, ".wr_data"},   ins_write_data,        32'd0);
        chk({tag, ".cpu_reset"}, {31'b0, cpu_reset},    32'd1);
        chk({tag, ".done"},      {31'b0, done},         32'd0);
        chk({tag, ".error"},     {31'b0, error},        32'd0);
        chk({tag, ".words"},     32'(words_loaded),     32'd0);
    endtask

    task automatic mk_frame(input int n, input bit good, output bq_t fr);
        logic [7:0] x, b;
        logic [15:0] n16;
        n16 = 16'(n);
        x = 8'h00;
        fr = {};
        fr.push_back(n16[7:0]);
        fr.push_back(n16[15:8]);
        for (int i = 0; i < 4*n; i++) begin
            b = 8'($urandom);
            x ^= b;
            fr.push_back(b);
        end
        fr.push_back(good ? x : (x ^ 8'($urandom_range(1, 255))));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t fa, fbad, fr;
        reset = 1'b0; in_valid = 1'b0; in_data = 8'h00; reload = 1'b0;
        // data xor: 13^93^10 = 90
        fa   = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
        fbad = fa;
        fbad[10] = 8'h81;

        @(negedge clk);
        #1;
        check_reset_vals("por");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        run(fa, 1'b0, fa.size(), "frameA");

        // DONE ignores incoming bytes
        in_valid = 1'b1;
        in_data  = 8'h55;
        repeat (4) begin
            #1;
            chk("done_poke.in_ready", {31'b0, in_ready}, 32'd0);
            chk("done_poke.done",     {31'b0, done},     32'd1);
            chk("done_poke.words",    32'(words_loaded), 32'd2);
            @(negedge clk);
        end
        in_valid = 1'b0;

        do_reload();
        run(fa, 1'b1, fa.size(), "frameA_rnd");
        do_reload();
        run(fbad, 1'b1, fbad.size(), "bad_csum");
        do_reload();

        fr = '{8'h01, 8'h01};
        run(fr, 1'b0, 2, "too_big");
        do_reload();
        fr = '{8'h00, 8'h00, 8'h00};
        run(fr, 1'b1, 3, "zero_cnt");
        do_reload();

        // Reset mid-load: word 0 written, word 1 half received
        run(fa, 1'b0, 8, "partial");
        reset = 1'b0;
        #1;
        check_reset_vals("midreset");
        chk("midreset.pending", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        run(fa, 1'b1, fa.size(), "after_reset");

        do_reload();
        fr = '{8'h01, 8'h00, 8'haa, 8'hbb, 8'hcc, 8'hdd, 8'h00};
        fr[6] = 8'haa ^ 8'hbb ^ 8'hcc ^ 8'hdd;
        run(fr, 1'b1, fr.size(), "one_word");

        for (int k = 0; k < 10; k++) begin
            do_reload();
            mk_frame($urandom_range(1, 8), ($urandom_range(0, 3) != 0), fr);
            run(fr, 1'b1, fr.size(), "random");
        end

        do_reload();
        mk_frame(MAXW, 1'b1, fr);
        run(fr, 1'b0, fr.size(), "max_words");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
